// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on {acc, opnd, cnt}.
module muldiv_step #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CW   = 5
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    input  logic [CW-1:0]     cnt_in,
    output logic [2*XLEN-1:0] acc_out,
    output logic [CW-1:0]     cnt_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, opnd};
        shifted = acc_in[2*XLEN-1:XLEN-1];
        trial   = shifted - {1'b0, opnd};
        cnt_out = cnt_in - CW'(1);
        if (is_div) begin
            if (trial[XLEN]) begin
                acc_out = {shifted[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end else begin
                acc_out = {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            end
        end else if (acc_in[0]) begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end else begin
            acc_out = {1'b0, acc_in[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide responder; MULDIV_FASTMUL_EN selects a single-cycle multiply.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] result,
    output logic            valid,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);

    state_t              state;
    logic [2:0]          op;
    logic                neg;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opnd;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc_nx;
    logic [CW-1:0]       cnt_nx;

    logic                a_sgn, b_sgn, sa, sb, neg_in;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                special;
    logic [XLEN-1:0]     special_val;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     rem_quo;
    logic [XLEN-1:0]     fix_val;
`ifdef MULDIV_FASTMUL_EN
    logic signed [2*XLEN+1:0] fast_prod;
`endif

    muldiv_step #(.XLEN(XLEN), .CW(CW)) u_step (
        .is_div  (op[2]),
        .acc_in  (acc),
        .opnd    (opnd),
        .cnt_in  (cnt),
        .acc_out (acc_nx),
        .cnt_out (cnt_nx)
    );

    // Operand sign conversion and special-case resolution at accept.
    always_comb begin
        a_sgn  = (func3 == F3_MULH) || (func3 == F3_MULHSU) || (func3 == F3_DIV) || (func3 == F3_REM);
        b_sgn  = (func3 == F3_MULH) || (func3 == F3_DIV) || (func3 == F3_REM);
        sa     = a_sgn & opa[XLEN-1];
        sb     = b_sgn & opb[XLEN-1];
        mag_a  = sa ? -opa : opa;
        mag_b  = sb ? -opb : opb;
        neg_in = (func3 == F3_REM) ? sa : (sa ^ sb);
        special     = 1'b0;
        special_val = '0;
        if (func3[2]) begin
            if (opb == '0) begin
                special     = 1'b1;
                special_val = func3[1] ? opa : {XLEN{1'b1}};
            end else if (!func3[0] && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == {XLEN{1'b1}})) begin
                special     = 1'b1;
                special_val = func3[1] ? '0 : opa;
            end
        end
`ifdef MULDIV_FASTMUL_EN
        fast_prod = $signed({sa & 1'b1 & a_sgn & opa[XLEN-1], opa}) * $signed({b_sgn & opb[XLEN-1], opb});
        if (!func3[2]) begin
            special     = 1'b1;
            special_val = (func3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // Sign fix-up of the final iteration's accumulator.
    always_comb begin
        prod    = neg ? -acc_nx : acc_nx;
        rem_quo = op[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
        if (op[2]) begin
            fix_val = neg ? -rem_quo : rem_quo;
        end else if (op == F3_MUL) begin
            fix_val = prod[XLEN-1:0];
        end else begin
            fix_val = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            valid  <= 1'b0;
            busy   <= 1'b0;
            result <= '0;
            op     <= F3_MUL;
            neg    <= 1'b0;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    acc <= acc_nx;
                    cnt <= cnt_nx;
                    if (cnt == '0) begin
                        result <= fix_val;
                        state  <= S_DONE;
                        valid  <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (start) begin
                        op  <= func3;
                        neg <= neg_in;
                        if (special) begin
                            result <= special_val;
                            state  <= S_DONE;
                            valid  <= 1'b1;
                        end else begin
                            acc   <= func3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                            opnd  <= func3[2] ? mag_b : mag_a;
                            cnt   <= CW'(XLEN - 1);
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;
    localparam int ITER_LAT = XLEN + 1;
`ifdef MULDIV_FASTMUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = ITER_LAT;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] opa, opb;
    logic [XLEN-1:0] result;
    logic            valid, busy;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .func3(func3),
        .opa(opa), .opb(opb), .result(result), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive one request (caller is 1 ns after an edge) and wait, bounded, for valid.
    task automatic run_op(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          output int lat, output logic [XLEN-1:0] res);
        start = 1'b1; func3 = f; opa = a; opb = b;
        lat = 0; res = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (valid) begin
                lat = i; res = result;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    endtask

    task automatic test_mul;
        int lat; logic [XLEN-1:0] res;
        run_op(3'b000, 32'h7, 32'hFFFF_FFFD, lat, res);
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_res got=%h exp=ffffffeb", res); end
        checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL mul_lat got=%0d exp=%0d", lat, MUL_LAT); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_to_idle got=%b%b exp=00", valid, busy); end
        checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL result_hold got=%h exp=ffffffeb", result); end
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, lat, res);
        checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL mulh_res got=%h exp=40000000", res); end
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_res got=%h exp=ffffffff", res); end
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
        checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_res got=%h exp=fffffffe", res); end
        run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0003, lat, res);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulh_neg got=%h exp=ffffffff", res); end
        checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL mulh_lat got=%0d exp=%0d", lat, MUL_LAT); end
    endtask

    task automatic test_div;
        int lat; logic [XLEN-1:0] res;
        run_op(3'b100, 32'hFFFF_FFF9, 32'h2, lat, res);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_res got=%h exp=fffffffd", res); end
        checks++; if (lat != ITER_LAT) begin errors++; $display("FAIL div_lat got=%0d exp=%0d", lat, ITER_LAT); end
        run_op(3'b110, 32'hFFFF_FFF9, 32'h2, lat, res);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_res got=%h exp=ffffffff", res); end
        run_op(3'b101, 32'd100, 32'd7, lat, res);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_res got=%h exp=0000000e", res); end
        run_op(3'b111, 32'd100, 32'd7, lat, res);
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_res got=%h exp=00000002", res); end
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, lat, res);
        checks++; if (res !== 32'd1) begin errors++; $display("FAIL rem_posdvd got=%h exp=00000001", res); end
        run_op(3'b100, 32'd7, 32'hFFFF_FFFE, lat, res);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdvs got=%h exp=fffffffd", res); end
    endtask

    task automatic test_special;
        int lat; logic [XLEN-1:0] res;
        run_op(3'b100, 32'd1234, 32'd0, lat, res);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_res got=%h exp=ffffffff", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL div0_lat got=%0d exp=1", lat); end
        run_op(3'b110, 32'd5, 32'd0, lat, res);
        checks++; if (res !== 32'd5) begin errors++; $display("FAIL rem0_res got=%h exp=00000005", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL rem0_lat got=%0d exp=1", lat); end
        run_op(3'b101, 32'd9, 32'd0, lat, res);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_res got=%h exp=ffffffff", res); end
        run_op(3'b111, 32'd9, 32'd0, lat, res);
        checks++; if (res !== 32'd9) begin errors++; $display("FAIL remu0_res got=%h exp=00000009", res); end
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL divovf_res got=%h exp=80000000", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL divovf_lat got=%0d exp=1", lat); end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL removf_res got=%h exp=00000000", res); end
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL divu_big got=%h exp=00000000", res); end
        checks++; if (lat != ITER_LAT) begin errors++; $display("FAIL divu_big_lat got=%0d exp=%0d", lat, ITER_LAT); end
    endtask

    task automatic test_start_in_run;
        int lat; logic [XLEN-1:0] res;
        lat = 0;
        start = 1'b1; func3 = 3'b100; opa = 32'hFFFF_FFF9; opb = 32'h2;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (i <= 10) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy cyc=%0d got=%b exp=1", i, busy); end
                func3 = 3'(i); opa = $urandom; opb = $urandom;
            end else begin
                start = 1'b0;
            end
            if (valid) begin lat = i; break; end
        end
        checks++; if (result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL hold_res got=%h exp=fffffffd", result); end
        checks++; if (lat != ITER_LAT) begin errors++; $display("FAIL hold_lat got=%0d exp=%0d", lat, ITER_LAT); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [XLEN-1:0] res;
        run_op(3'b101, 32'd100, 32'd7, lat, res);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL b2b_first got=%h exp=0000000e", res); end
        run_op(3'b111, 32'd100, 32'd7, lat, res);
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL b2b_second got=%h exp=00000002", res); end
        checks++; if (lat != ITER_LAT) begin errors++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, ITER_LAT); end
        run_op(3'b100, 32'd3, 32'd0, lat, res);
        checks++; if (res !== 32'hFFFF_FFFF || lat != 1) begin errors++; $display("FAIL b2b_special got=%h/%0d exp=ffffffff/1", res, lat); end
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        start = 1'b1; func3 = 3'b101; opa = 32'd100; opb = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got=%b exp=1", busy); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (result !== '0) begin errors++; $display("FAIL rst_result got=%h exp=0", result); end
        seen = 1'b0;
        for (int i = 0; i < 2 * ITER_LAT; i++) begin
            if (valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_abort_valid got=1 exp=0"); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; func3 = '0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
